// File: rtl/n_risc.sv
`default_nettype none
// ============================================================================
//  Module   : n_risc
//  Purpose  : Single-cycle 8-bit processor core (nRisc). Eight 8-bit
//             registers, 3-bit opcode, 8-bit instructions, one instruction
//             per clock. Instruction and data memories are external.
//  Ports    : Clock              - rising-edge clock
//             reset              - synchronous, active-high
//             Instrucao[7:0]     - instruction at current PC
//             SaidaPCLeEndereco  - current PC (instruction-memory address)
//             LeDado[7:0]        - data-memory read data
//             Data2[7:0]         - R[rB], data-memory address
//             Data1[7:0]         - R[rA], data-memory write data
//             EscMem / LerMem    - data-memory write / read enables
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  n_risc_controle : decodes the opcode into datapath controls.
// ----------------------------------------------------------------------------
module n_risc_controle (
    input  logic [2:0] op,
    output logic       Beqz,      // conditional branch on R[rA]==0
    output logic       RegFonte,  // 1: write back LeDado, 0: ALU result
    output logic       ULAOp,     // 1: subtract, 0: add
    output logic       EscMem,
    output logic       ULAFonte,  // 1: imm2 operand, 0: R[rB]
    output logic       LerMem,
    output logic       SelDest,   // 1: next PC taken from R[rB]
    output logic       Ji,        // PC-relative jump
    output logic       EscReg,
    output logic       EscPC
);
    localparam logic [2:0] C_OP_ADD  = 3'b000;
    localparam logic [2:0] C_OP_SUB  = 3'b001;
    localparam logic [2:0] C_OP_ADDI = 3'b010;
    localparam logic [2:0] C_OP_LW   = 3'b011;
    localparam logic [2:0] C_OP_SW   = 3'b100;
    localparam logic [2:0] C_OP_BEQZ = 3'b101;
    localparam logic [2:0] C_OP_J    = 3'b110;

    always_comb begin
        Beqz     = 1'b0;
        RegFonte = 1'b0;
        ULAOp    = 1'b0;
        EscMem   = 1'b0;
        ULAFonte = 1'b0;
        LerMem   = 1'b0;
        SelDest  = 1'b0;
        Ji       = 1'b0;
        EscReg   = 1'b0;
        EscPC    = 1'b1;
        case (op)
            C_OP_ADD:  EscReg = 1'b1;
            C_OP_SUB:  begin EscReg = 1'b1; ULAOp = 1'b1; end
            C_OP_ADDI: begin EscReg = 1'b1; ULAFonte = 1'b1; end
            C_OP_LW:   begin EscReg = 1'b1; LerMem = 1'b1; RegFonte = 1'b1; end
            C_OP_SW:   EscMem = 1'b1;
            C_OP_BEQZ: begin Beqz = 1'b1; SelDest = 1'b1; end
            C_OP_J:    Ji = 1'b1;
            default:   EscPC = 1'b0;   // HALT freezes the PC
        endcase
    end
endmodule

// ----------------------------------------------------------------------------
//  n_risc_banco_reg : 8x8 register file, two async reads, one sync write.
//  A read in the same cycle as a write to that register sees the old value.
// ----------------------------------------------------------------------------
module n_risc_banco_reg (
    input  logic       Clock,
    input  logic       reset,
    input  logic       EscReg,
    input  logic [2:0] RegA,
    input  logic [2:0] RegB,
    input  logic [2:0] RegWrite,   // destination register index
    input  logic [7:0] WriteData,
    output logic [7:0] Data1,
    output logic [7:0] Data2
);
    logic [7:0] RF [0:7];

    always_ff @(posedge Clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) RF[i] <= 8'h00;
        end else if (EscReg) begin
            RF[RegWrite] <= WriteData;
        end
    end

    assign Data1 = RF[RegA];
    assign Data2 = RF[RegB];
endmodule

// ----------------------------------------------------------------------------
//  n_risc : top-level core.
// ----------------------------------------------------------------------------
module n_risc (
    input  logic       Clock,
    input  logic       reset,
    input  logic [7:0] Instrucao,
    output logic [7:0] SaidaPCLeEndereco,
    input  logic [7:0] LeDado,
    output logic [7:0] Data2,
    output logic [7:0] Data1,
    output logic       EscMem,
    output logic       LerMem
);
    logic [7:0] pc_q;
    logic [7:0] EntradaPC;          // next-PC value, loaded into pc_q

    logic       Beqz, RegFonte, ULAOp, EscMemCtl, ULAFonte;
    logic       SelDest, Ji, EscReg, EscPC;

    logic [2:0] w_ra;
    logic [2:0] w_rb;
    logic [7:0] w_imm2;
    logic [7:0] w_off5;
    logic [7:0] w_ula_b;
    logic [7:0] w_ula_res;
    logic [7:0] WriteData;

    assign w_ra   = Instrucao[4:2];
    assign w_rb   = {1'b0, Instrucao[1:0]};
    assign w_imm2 = {{6{Instrucao[1]}}, Instrucao[1:0]};
    assign w_off5 = {{3{Instrucao[4]}}, Instrucao[4:0]};

    n_risc_controle controle (
        .op       (Instrucao[7:5]),
        .Beqz     (Beqz),
        .RegFonte (RegFonte),
        .ULAOp    (ULAOp),
        .EscMem   (EscMemCtl),
        .ULAFonte (ULAFonte),
        .LerMem   (LerMem),
        .SelDest  (SelDest),
        .Ji       (Ji),
        .EscReg   (EscReg),
        .EscPC    (EscPC)
    );

    n_risc_banco_reg BancoReg (
        .Clock     (Clock),
        .reset     (reset),
        .EscReg    (EscReg),
        .RegA      (w_ra),
        .RegB      (w_rb),
        .RegWrite  (w_ra),
        .WriteData (WriteData),
        .Data1     (Data1),
        .Data2     (Data2)
    );

    // ALU: mod-256 add/sub, no flags.
    assign w_ula_b   = ULAFonte ? w_imm2 : Data2;
    assign w_ula_res = ULAOp ? (Data1 - w_ula_b) : (Data1 + w_ula_b);
    assign WriteData = RegFonte ? LeDado : w_ula_res;

    // Memory writes are suppressed while reset is held, even if the word
    // at PC 0 happens to be a store.
    assign EscMem = EscMemCtl & ~reset;

    always_comb begin
        EntradaPC = pc_q + 8'd1;
        if (!EscPC) begin
            EntradaPC = pc_q;
        end else if (Ji) begin
            EntradaPC = pc_q + w_off5;
        end else if (SelDest && Beqz && (Data1 == 8'h00)) begin
            EntradaPC = Data2;
        end
    end

    always_ff @(posedge Clock) begin
        if (reset) pc_q <= 8'h00;
        else       pc_q <= EntradaPC;
    end

    assign SaidaPCLeEndereco = pc_q;
endmodule
`default_nettype wire

// File: tb/tb_n_risc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_n_risc
//  Purpose  : Directed self-checking bench for n_risc. Instruction ROM and
//             data memory are small behavioural models driven by the core.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_n_risc;
    logic       Clock;
    logic       reset;
    logic [7:0] Instrucao;
    logic [7:0] SaidaPCLeEndereco;
    logic [7:0] LeDado;
    logic [7:0] Data2;
    logic [7:0] Data1;
    logic       EscMem;
    logic       LerMem;

    logic [7:0] prog [0:255];
    logic [7:0] dmem [0:255];

    int n_vec;
    int n_err;

    n_risc dut (
        .Clock             (Clock),
        .reset             (reset),
        .Instrucao         (Instrucao),
        .SaidaPCLeEndereco (SaidaPCLeEndereco),
        .LeDado            (LeDado),
        .Data2             (Data2),
        .Data1             (Data1),
        .EscMem            (EscMem),
        .LerMem            (LerMem)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign Instrucao = prog[SaidaPCLeEndereco];
    assign LeDado    = LerMem ? dmem[Data2] : 8'h00;

    always @(posedge Clock) begin
        if (EscMem) dmem[Data2] <= Data1;
    end

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) prog[i] = 8'hE0;
    endtask

    task automatic check_rf_zero(input string tag);
        for (int i = 0; i < 8; i++) check8(tag, dut.BancoReg.RF[i], 8'h00);
    endtask

    // Apply reset for n clocks and leave it asserted.
    task automatic hold_reset(input int n);
        reset = 1'b1;
        step(n);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;

        // ---- Reset: every word is SW, so EscMem must stay low under reset
        for (int i = 0; i < 256; i++) prog[i] = 8'h86;
        hold_reset(2);
        check8("rst_pc", SaidaPCLeEndereco, 8'h00);
        check8("rst_escmem", {7'd0, EscMem}, 8'h00);
        check_rf_zero("rst_rf");

        // ---- Arithmetic: ADDI R1,+1 x3; ADDI R2,-2; ADD R1,R2; SUB R3,R1
        fill_halt();
        prog[0] = 8'h45; prog[1] = 8'h45; prog[2] = 8'h45;
        prog[3] = 8'h4A; prog[4] = 8'h06; prog[5] = 8'h2D;
        reset = 1'b0;
        step(1);
        check8("pc_inc1", SaidaPCLeEndereco, 8'h01);
        check8("addi_r1", dut.BancoReg.RF[1], 8'h01);
        step(1);
        check8("pc_inc2", SaidaPCLeEndereco, 8'h02);
        step(4);
        check8("arith_pc", SaidaPCLeEndereco, 8'h06);
        check8("arith_r1", dut.BancoReg.RF[1], 8'h01);
        check8("arith_r2", dut.BancoReg.RF[2], 8'hFE);
        check8("arith_r3", dut.BancoReg.RF[3], 8'hFF);

        // ---- SW/LW: R1=3, R2=1; SW R1,(R2); LW R4,(R2)
        hold_reset(1);
        fill_halt();
        prog[0] = 8'h45; prog[1] = 8'h45; prog[2] = 8'h45; prog[3] = 8'h49;
        prog[4] = 8'h86; prog[5] = 8'h72;
        reset = 1'b0;
        step(4);
        check8("sw_pc", SaidaPCLeEndereco, 8'h04);
        check8("sw_escmem", {7'd0, EscMem}, 8'h01);
        check8("sw_lermem", {7'd0, LerMem}, 8'h00);
        check8("sw_addr", Data2, 8'h01);
        check8("sw_data", Data1, 8'h03);
        step(1);
        check8("mem1", dmem[1], 8'h03);
        check8("lw_lermem", {7'd0, LerMem}, 8'h01);
        check8("lw_escmem", {7'd0, EscMem}, 8'h00);
        step(1);
        check8("lw_r4", dut.BancoReg.RF[4], 8'h03);
        check8("halt_lermem", {7'd0, LerMem}, 8'h00);

        // ---- BEQZ taken (R5=0 -> PC=R3=6), then not taken (R5=1)
        hold_reset(1);
        fill_halt();
        prog[0] = 8'h4D; prog[1] = 8'h4D; prog[2] = 8'h4D; prog[3] = 8'h0F;
        prog[4] = 8'hB7; prog[6] = 8'h55; prog[7] = 8'hB7;
        reset = 1'b0;
        step(4);
        check8("beqz_r3", dut.BancoReg.RF[3], 8'h06);
        step(1);
        check8("beqz_taken", SaidaPCLeEndereco, 8'h06);
        step(1);
        check8("beqz_r5", dut.BancoReg.RF[5], 8'h01);
        step(1);
        check8("beqz_not_taken", SaidaPCLeEndereco, 8'h08);

        // ---- J: +7 to 10, -3 to 7, BEQZ R0,R1 to 250, J +15 wraps to 9
        hold_reset(1);
        fill_halt();
        prog[0] = 8'h46; prog[1] = 8'h46; prog[2] = 8'h46; prog[3] = 8'hC7;
        prog[10] = 8'hDD; prog[7] = 8'hA1; prog[250] = 8'hCF;
        reset = 1'b0;
        step(4);
        check8("j_fwd", SaidaPCLeEndereco, 8'h0A);
        check8("j_r1", dut.BancoReg.RF[1], 8'hFA);
        step(1);
        check8("j_back", SaidaPCLeEndereco, 8'h07);
        step(1);
        check8("beqz_far", SaidaPCLeEndereco, 8'hFA);
        step(1);
        check8("j_wrap", SaidaPCLeEndereco, 8'h09);
        step(1);
        check8("j_halted", SaidaPCLeEndereco, 8'h09);

        // ---- HALT at PC=4 holds PC and RF for 10 clocks; reset recovers
        hold_reset(1);
        fill_halt();
        prog[0] = 8'h45; prog[1] = 8'h49; prog[2] = 8'h4D; prog[3] = 8'h45;
        reset = 1'b0;
        step(4);
        check8("halt_pc", SaidaPCLeEndereco, 8'h04);
        step(10);
        check8("halt_pc_hold", SaidaPCLeEndereco, 8'h04);
        check8("halt_r1", dut.BancoReg.RF[1], 8'h02);
        check8("halt_r2", dut.BancoReg.RF[2], 8'h01);
        check8("halt_r3", dut.BancoReg.RF[3], 8'h01);
        hold_reset(1);
        check8("halt_rst_pc", SaidaPCLeEndereco, 8'h00);
        check_rf_zero("halt_rst_rf");
        check8("mem_kept", dmem[1], 8'h03);
        reset = 1'b0;
        step(1);
        check8("post_rst_pc", SaidaPCLeEndereco, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
